// File: rtl/alu_multibyte_ctrl.sv
// Byte-serial sequencer driving an external 8-bit ALU over NBYTES-wide operands, LSB first.
// Define ALU_CTRL_SUB_EN to make op 2'b11 a subtract; otherwise 2'b11 is rejected via err.
`ifndef ADD_FN
`define ADD_FN 2'b00
`endif
`ifndef AND_FN
`define AND_FN 2'b01
`endif
`ifndef OR_FN
`define OR_FN  2'b10
`endif

module alu_multibyte_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  c_in,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic [2:0]            czn,
   output logic                  err,
   output logic [7:0]            alu_in1,
   output logic [7:0]            alu_in2,
   output logic                  alu_c_in,
   output logic [1:0]            alu_opcode,
   input  logic [7:0]            alu_out,
   input  logic [2:0]            CZN_from_ALU
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [W-1:0]  a_r, b_r;
   logic [1:0]    op_r;
   logic          sub_r, carry, zacc, arith;
   logic [IW-1:0] idx;
   logic          last, op_legal, op_sub;

   // The ALU's own N and Z are not trusted across bytes; N/Z come from the word.
   logic unused_alu_flags;
   assign unused_alu_flags = ^CZN_from_ALU[2:1];

   assign last  = (idx == IW'(NBYTES - 1));
   assign arith = sub_r | (op_r == `ADD_FN);

   always_comb begin
      op_sub   = 1'b0;
      op_legal = 1'b1;
`ifdef ALU_CTRL_SUB_EN
      op_sub   = (op == 2'b11);
`else
      op_legal = (op != 2'b11);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = op_legal ? RUN : DONE;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      done       = (state == DONE);
      alu_in1    = 8'h00;
      alu_in2    = 8'h00;
      alu_c_in   = 1'b0;
      alu_opcode = 2'b00;
      if (state == RUN) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (idx == IW'(k)) begin
               alu_in1 = a_r[8*k +: 8];
               alu_in2 = b_r[8*k +: 8];
            end
         end
         alu_c_in   = arith & carry;
         alu_opcode = sub_r ? `ADD_FN : op_r;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         op_r   <= 2'b00;
         sub_r  <= 1'b0;
         carry  <= 1'b0;
         zacc   <= 1'b0;
         idx    <= '0;
         result <= '0;
         czn    <= 3'b000;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (op_legal) begin
                  // SUB is a + ~b + 1, so b is stored pre-inverted and carry seeded with 1
                  a_r    <= a;
                  b_r    <= op_sub ? ~b : b;
                  op_r   <= op;
                  sub_r  <= op_sub;
                  carry  <= op_sub | ((op == `ADD_FN) & c_in);
                  idx    <= '0;
                  zacc   <= 1'b1;
                  result <= '0;
               end else begin
                  err    <= 1'b1;
               end
            end
            RUN: begin
               for (int k = 0; k < NBYTES; k++)
                  if (idx == IW'(k)) result[8*k +: 8] <= alu_out;
               carry <= CZN_from_ALU[0];
               zacc  <= zacc & (alu_out == 8'h00);
               idx   <= idx + 1'b1;
               if (last) begin
                  czn <= {alu_out[7], zacc & (alu_out == 8'h00), arith & CZN_from_ALU[0]};
                  err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multibyte_ctrl.sv
// Directed bench for alu_multibyte_ctrl with a behavioural 8-bit ALU model attached.
module tb_alu_multibyte_ctrl;
   localparam int NB = 4;
   localparam int W  = 8 * NB;
   localparam logic [1:0] OP_ADD = 2'b00, OP_AND = 2'b01, OP_OR = 2'b10, OP_X = 2'b11;

   logic          clk = 1'b0, rst, start, c_in;
   logic [1:0]    op;
   logic [W-1:0]  a, b, result;
   logic          busy, done, err, alu_c_in;
   logic [2:0]    czn, CZN_from_ALU;
   logic [7:0]    alu_in1, alu_in2, alu_out;
   logic [1:0]    alu_opcode;
   logic [8:0]    sum;

   int n_tests = 0, n_fail = 0;
   int lat;
   time t0;

   always #5 clk = ~clk;

   alu_multibyte_ctrl #(.NBYTES(NB)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
      .busy(busy), .done(done), .result(result), .czn(czn), .err(err),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c_in(alu_c_in),
      .alu_opcode(alu_opcode), .alu_out(alu_out), .CZN_from_ALU(CZN_from_ALU)
   );

   // ALU model: C is the raw adder carry even for logic ops, N/Z deliberately inverted
   always_comb begin
      sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'h00, alu_c_in};
      case (alu_opcode)
         OP_ADD:  alu_out = sum[7:0];
         OP_AND:  alu_out = alu_in1 & alu_in2;
         OP_OR:   alu_out = alu_in1 | alu_in2;
         default: alu_out = 8'hA5;
      endcase
      CZN_from_ALU = {~alu_out[7], ~(alu_out == 8'h00), sum[8]};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, exp %0h", tag, got, exp);
      end
   endtask

   // Issues one op, measures accept-to-done latency, returns in the following IDLE cycle
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, output int l);
      @(negedge clk);
      op = o; a = x; b = y; c_in = ci; start = 1'b1;
      @(posedge clk);
      t0 = $time;
      #1 start = 1'b0;
      l = 1;
      while (!done && l < 50) begin
         @(posedge clk);
         #1 l++;
      end
      if (!done) chk("done_timeout", 64'(l), 64'(NB + 1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; c_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
      chk("rst_result", result, 0); chk("rst_czn", czn, 0); chk("rst_err", err, 0);
      chk("rst_alu", {alu_in1, alu_in2, alu_c_in, alu_opcode}, 0);

      // ADD with carry across byte 0->1, busy/latency checks
      @(negedge clk);
      op = OP_ADD; a = 32'h000000FF; b = 32'h00000001; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("add1_busy_run", busy, 1);
      chk("add1_alu_in1", alu_in1, 8'hFF);
      lat = 1;
      while (!done && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("add1_latency", 64'(lat), 64'(NB + 1));
      chk("add1_busy_done", busy, 1);
      chk("add1_result", result, 32'h00000100);
      chk("add1_czn", czn, 3'b000);
      @(posedge clk);
      #1;
      chk("add1_busy_after", busy, 0);
      chk("add1_done_after", done, 0);

      run_op(OP_ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
      chk("add2_result", result, 0);           chk("add2_czn", czn, 3'b011);
      run_op(OP_ADD, 32'h12345678, 32'h0F0F0F0F, 1'b0, lat);
      chk("add3_result", result, 32'h21436587); chk("add3_czn", czn, 3'b000);
      run_op(OP_ADD, 32'h80000000, 32'h80000000, 1'b0, lat);
      chk("add4_result", result, 0);           chk("add4_czn", czn, 3'b011);
      run_op(OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, lat);
      chk("and1_result", result, 0);           chk("and1_czn", czn, 3'b010);
      run_op(OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
      chk("and2_result", result, 32'hFFFFFFFF); chk("and2_czn", czn, 3'b100);
      run_op(OP_OR, 32'h80000000, 32'h00000000, 1'b0, lat);
      chk("or1_result", result, 32'h80000000); chk("or1_czn", czn, 3'b100);

`ifdef ALU_CTRL_SUB_EN
      run_op(OP_X, 32'h5, 32'h5, 1'b0, lat);
      chk("sub1_latency", 64'(lat), 64'(NB + 1));
      chk("sub1_result", result, 0);           chk("sub1_czn", czn, 3'b011);
      run_op(OP_X, 32'h0, 32'h1, 1'b1, lat);
      chk("sub2_result", result, 32'hFFFFFFFF); chk("sub2_czn", czn, 3'b100);
      chk("sub2_err", err, 0);
`else
      run_op(OP_X, 32'h5, 32'h5, 1'b0, lat);
      chk("ill_latency", 64'(lat), 64'd1);
      chk("ill_err", err, 1);
      chk("ill_result_held", result, 32'h80000000);
      chk("ill_czn_held", czn, 3'b100);
`endif
      run_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
      chk("add5_result", result, 32'h80000000); chk("add5_czn", czn, 3'b100);
      chk("add5_err", err, 0);

      // Asynchronous reset while byte 2 is on the ALU
      @(negedge clk);
      op = OP_ADD; a = 32'h01010101; b = 32'h01010101; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("pre_rst_in1", alu_in1, 8'h01);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);  chk("mid_rst_done", done, 0);
      chk("mid_rst_result", result, 0); chk("mid_rst_czn", czn, 0); chk("mid_rst_err", err, 0);
      chk("mid_rst_alu", {alu_in1, alu_in2, alu_c_in, alu_opcode}, 0);
      @(negedge clk) rst = 1'b0;
      run_op(OP_ADD, 32'd3, 32'd4, 1'b0, lat);
      chk("post_rst_result", result, 32'd7); chk("post_rst_czn", czn, 3'b000);

      // start during RUN must be ignored
      @(negedge clk);
      op = OP_ADD; a = 32'd1; b = 32'd1; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 op = OP_AND; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; c_in = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 2;
      while (!done && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("ign_latency", 64'(lat), 64'(NB + 1));
      chk("ign_result", result, 32'd2);
      chk("ign_czn", czn, 3'b000);
      @(posedge clk);
      #1;
      chk("ign_idle", busy, 0);

      // back-to-back throughput: accept-to-accept spacing NBYTES+2 cycles
      begin
         time ta;
         run_op(OP_OR, 32'h00000010, 32'h00000001, 1'b0, lat);
         ta = t0;
         chk("b2b1_result", result, 32'h11);
         run_op(OP_ADD, 32'h00000010, 32'h00000001, 1'b1, lat);
         chk("b2b2_result", result, 32'h12);
         chk("b2b_spacing", 64'((t0 - ta) / 10), 64'(NB + 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
